// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages and the stall/flush scheduler.
interface pipe_hazard_ctrl_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
);
   logic             if_stall_req_i;
   logic             id_loaduse_req_i;
   logic             ex_stall_req_i;
   logic             mem_stall_req_i;
   logic             ex_redirect_valid_i;
   logic [XLEN-1:0]  ex_redirect_pc_i;
   logic             trap_valid_i;
   logic [XLEN-1:0]  trap_pc_i;
   logic [5:0]       stall_valid_o;
   logic [5:0]       flush_valid_o;
   logic             pc_redirect_valid_o;
   logic [XLEN-1:0]  pc_redirect_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output if_stall_req_i, id_loaduse_req_i, ex_stall_req_i, mem_stall_req_i,
      output ex_redirect_valid_i, ex_redirect_pc_i, trap_valid_i, trap_pc_i,
      input  stall_valid_o, flush_valid_o, pc_redirect_valid_o, pc_redirect_o, stall_cnt_o
   );

   modport slave (
      input  if_stall_req_i, id_loaduse_req_i, ex_stall_req_i, mem_stall_req_i,
      input  ex_redirect_valid_i, ex_redirect_pc_i, trap_valid_i, trap_pc_i,
      output stall_valid_o, flush_valid_o, pc_redirect_valid_o, pc_redirect_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline; defers redirects while a fetch is outstanding.
//   state | meaning
//   RUN   | normal issue, redirects go straight to the PC
//   PEND  | redirect owed in pend_pc, wrong-path fetch still in flight
module pipe_hazard_ctrl #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);
   typedef enum logic {RUN, PEND} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [5:0]       stall, flush;
   logic             redir_vld;
   logic [XLEN-1:0]  redir_pc;

   always_comb begin
      stall     = 6'b0;
      flush     = 6'b0;
      redir_vld = 1'b0;
      redir_pc  = '0;
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      if (!rst) begin
         flush     = 6'b011110;
         state_d   = RUN;
         pend_pc_d = '0;
      end else if (state_q == RUN) begin
         if (hz.trap_valid_i && !hz.mem_stall_req_i) begin
            flush = 6'b001110;
            if (hz.if_stall_req_i) begin
               stall     = 6'b000001;
               pend_pc_d = hz.trap_pc_i;
               state_d   = PEND;
            end else begin
               redir_vld = 1'b1;
               redir_pc  = hz.trap_pc_i;
            end
         end else if (hz.mem_stall_req_i) begin
            stall = 6'b001111;
            flush = 6'b010000;
         end else if (hz.ex_stall_req_i) begin
            stall = 6'b000111;
            flush = 6'b001000;
         end else if (hz.ex_redirect_valid_i) begin
            flush = 6'b000110;
            if (hz.if_stall_req_i) begin
               stall     = 6'b000001;
               pend_pc_d = hz.ex_redirect_pc_i;
               state_d   = PEND;
            end else begin
               redir_vld = 1'b1;
               redir_pc  = hz.ex_redirect_pc_i;
            end
         end else if (hz.id_loaduse_req_i) begin
            stall = 6'b000011;
            flush = 6'b000100;
         end else if (hz.if_stall_req_i) begin
            stall = 6'b000001;
            flush = 6'b000010;
         end
      end else begin
         // ID/EX keep taking bubbles until the owed redirect reaches the PC
         if (hz.mem_stall_req_i) begin
            stall = 6'b001111;
            flush = 6'b010000;
         end else if (hz.trap_valid_i) begin
            flush     = 6'b001110;
            pend_pc_d = hz.trap_pc_i;
            if (hz.if_stall_req_i) begin
               stall = 6'b000001;
            end else begin
               redir_vld = 1'b1;
               redir_pc  = hz.trap_pc_i;
               state_d   = RUN;
            end
         end else if (hz.if_stall_req_i) begin
            stall = 6'b000001;
            flush = 6'b000110;
         end else begin
            flush     = 6'b000110;
            redir_vld = 1'b1;
            redir_pc  = pend_pc_q;
            state_d   = RUN;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!rst)
         stall_cnt_d = '0;
      else if (stall[0] && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
   end

   assign hz.stall_valid_o       = stall;
   assign hz.flush_valid_o       = flush;
   assign hz.pc_redirect_valid_o = redir_vld;
   assign hz.pc_redirect_o       = redir_pc;
   assign hz.stall_cnt_o         = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl, built with a 4-bit stall counter.
module tb_pipe_hazard_ctrl;
   localparam int XLEN  = 64;
   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   logic [CNT_W-1:0] exp_cnt;

   pipe_hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ifs lu exs mems exr trap, in that order
   task automatic drive(input logic r, input logic [5:0] req,
                        input logic [63:0] exr_pc, input logic [63:0] trap_pc);
      rst                     = r;
      bus.if_stall_req_i      = req[5];
      bus.id_loaduse_req_i    = req[4];
      bus.ex_stall_req_i      = req[3];
      bus.mem_stall_req_i     = req[2];
      bus.ex_redirect_valid_i = req[1];
      bus.trap_valid_i        = req[0];
      bus.ex_redirect_pc_i    = exr_pc;
      bus.trap_pc_i           = trap_pc;
   endtask

   // Checks outputs mid-cycle, then advances one clock and updates the counter model.
   task automatic expect_out(input string tag, input logic [5:0] st, input logic [5:0] fl,
                             input logic rv, input logic [63:0] rpc);
      @(negedge clk);
      chk({tag, ".stall"}, 64'(bus.stall_valid_o), 64'(st));
      chk({tag, ".flush"}, 64'(bus.flush_valid_o), 64'(fl));
      chk({tag, ".rv"},    64'(bus.pc_redirect_valid_o), 64'(rv));
      chk({tag, ".rpc"},   bus.pc_redirect_o, rpc);
      chk({tag, ".cnt"},   64'(bus.stall_cnt_o), 64'(exp_cnt));
      chk({tag, ".inv"},   64'(bus.stall_valid_o & bus.flush_valid_o), 64'd0);
      @(posedge clk);
      #1;
      if (!rst)
         exp_cnt = '0;
      else if (st[0] && exp_cnt != 4'hF)
         exp_cnt = exp_cnt + 4'd1;
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
         expect_out("reset", 6'h00, 6'h1E, 1'b0, 64'd0);
      end
   endtask

   initial begin
      n_chk   = 0;
      n_err   = 0;
      exp_cnt = '0;
      drive(1'b0, 6'b0, 64'd0, 64'd0);
      @(posedge clk);
      #1;
      do_reset(3);

      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("idle", 6'h00, 6'h00, 1'b0, 64'd0);

      // Priority chain
      drive(1'b1, 6'b111100, 64'd0, 64'd0);
      expect_out("prio_mem", 6'h0F, 6'h10, 1'b0, 64'd0);
      drive(1'b1, 6'b111010, 64'h8000_0040, 64'd0);
      expect_out("prio_ex", 6'h07, 6'h08, 1'b0, 64'd0);
      drive(1'b1, 6'b010000, 64'd0, 64'd0);
      expect_out("loaduse", 6'h03, 6'h04, 1'b0, 64'd0);
      drive(1'b1, 6'b100000, 64'd0, 64'd0);
      expect_out("ifstall", 6'h01, 6'h02, 1'b0, 64'd0);

      // Redirect with fetch idle
      drive(1'b1, 6'b000010, 64'h8000_0040, 64'd0);
      expect_out("redir_idle", 6'h00, 6'h06, 1'b1, 64'h8000_0040);
      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("redir_idle_after", 6'h00, 6'h00, 1'b0, 64'd0);

      // Redirect with fetch busy for 4 cycles
      drive(1'b1, 6'b100010, 64'h8000_0100, 64'd0);
      expect_out("busy1", 6'h01, 6'h06, 1'b0, 64'd0);
      drive(1'b1, 6'b100000, 64'd0, 64'd0);
      for (int i = 0; i < 3; i++)
         expect_out("busy_pend", 6'h01, 6'h06, 1'b0, 64'd0);
      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("busy_issue", 6'h00, 6'h06, 1'b1, 64'h8000_0100);
      expect_out("busy_after", 6'h00, 6'h00, 1'b0, 64'd0);

      // Trap overrides a pending redirect
      drive(1'b1, 6'b100010, 64'h8000_0100, 64'd0);
      expect_out("tov_enter", 6'h01, 6'h06, 1'b0, 64'd0);
      drive(1'b1, 6'b000001, 64'd0, 64'h8000_0004);
      expect_out("tov_trap", 6'h00, 6'h0E, 1'b1, 64'h8000_0004);
      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("tov_after", 6'h00, 6'h00, 1'b0, 64'd0);

      // PEND: mem_stall holds, trap with fetch busy retargets, then issue
      drive(1'b1, 6'b100010, 64'h200, 64'd0);
      expect_out("pm_enter", 6'h01, 6'h06, 1'b0, 64'd0);
      drive(1'b1, 6'b100100, 64'd0, 64'd0);
      expect_out("pm_mem", 6'h0F, 6'h10, 1'b0, 64'd0);
      drive(1'b1, 6'b101011, 64'h999, 64'h300);
      expect_out("pm_trap_busy", 6'h01, 6'h0E, 1'b0, 64'd0);
      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("pm_issue", 6'h00, 6'h06, 1'b1, 64'h300);

      // RUN traps
      drive(1'b1, 6'b000101, 64'd0, 64'h400);
      expect_out("trap_mem", 6'h0F, 6'h10, 1'b0, 64'd0);
      drive(1'b1, 6'b011001, 64'h123, 64'h500);
      expect_out("trap_run", 6'h00, 6'h0E, 1'b1, 64'h500);
      drive(1'b1, 6'b100001, 64'd0, 64'h600);
      expect_out("trap_busy", 6'h01, 6'h0E, 1'b0, 64'd0);
      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("trap_issue", 6'h00, 6'h06, 1'b1, 64'h600);

      // Reset while a redirect is pending discards it
      drive(1'b1, 6'b100010, 64'h700, 64'd0);
      expect_out("rp_enter", 6'h01, 6'h06, 1'b0, 64'd0);
      drive(1'b0, 6'b000000, 64'd0, 64'd0);
      expect_out("rp_reset", 6'h00, 6'h1E, 1'b0, 64'd0);
      drive(1'b1, 6'b000000, 64'd0, 64'd0);
      expect_out("rp_after", 6'h00, 6'h00, 1'b0, 64'd0);

      // Counter saturation
      drive(1'b1, 6'b100000, 64'd0, 64'd0);
      for (int i = 0; i < 20; i++)
         expect_out("sat", 6'h01, 6'h02, 1'b0, 64'd0);
      @(negedge clk);
      chk("cnt_sat", 64'(bus.stall_cnt_o), 64'h0F);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
